inst_frame_decoder: RTL and testbench
=====================================

// Module: inst_frame_decoder
// PURPOSE
//   Parametrised instruction-frame front end between fetch and the control/ALU decode stage.
//   - Assembles one opcode word plus 0..MAX_ARGS argument words from a valid/ready fetch stream.
//   - Presents each complete instruction as one parallel bundle on a valid/ready output.
//   - On interrupt, pushes any partially assembled frame onto a SAVE_DEPTH-deep shadow stack.
//   - On interrupt return, pops that frame and resumes assembly where it stopped.
// PARAMETERS
//   DATA_W      16  width of the fetch word, the opcode and each argument
//   MAX_ARGS    3   maximum argument words per instruction (>=1)
//   ARGC_LSB    12  LSB of the arg-count field in the opcode; field width AW=$clog2(MAX_ARGS+1)
//   SAVE_DEPTH  2   nesting depth of the interrupt save stack (>=1)
// PORTS
//   clk           in   1                 clock, all state on posedge
//   rst           in   1                 asynchronous reset, active-high
//   i_fetch_data  in   DATA_W            fetched word
//   i_fetch_valid in   1                 fetch word valid
//   o_fetch_ready out  1                 decoder accepts a word this cycle
//   o_inst_valid  out  1                 instruction bundle valid
//   i_inst_ready  in   1                 downstream accepts the bundle
//   o_opcode      out  DATA_W            opcode word
//   o_argc        out  AW                argument count of o_opcode
//   o_args        out  MAX_ARGS*DATA_W   arg k in bits [k*DATA_W +: DATA_W]; unused slots are 0
//   i_interrupt   in   1                 interrupt request, level, sampled every cycle
//   i_int_return  in   1                 return-from-interrupt request
//   o_int_ack     out  1                 1-cycle pulse: frame saved, decoder ready for the ISR
//   o_save_full   out  1                 stack holds SAVE_DEPTH frames
//   o_save_empty  out  1                 stack holds no frames
//   o_err         out  1                 1-cycle pulse: illegal argc, stack overflow or stack underflow
// BEHAVIOUR
//   - Reset values: state OPC, stack empty, o_save_empty=1. All other outputs 0.
//     o_fetch_ready is held 0 while rst=1.
//   - A handshake is valid&&ready on a rising clk.
//   - States:
//     * OPC: o_fetch_ready=1.
//       - On handshake: latch the opcode, argc=opcode[ARGC_LSB+:AW], clear all args, cnt=0.
//       - Next state is HOLD if argc==0, otherwise ARGS.
//     * ARGS: o_fetch_ready=1.
//       - Each handshake writes arg[cnt] and increments cnt.
//       - The handshake with cnt==argc-1 moves to HOLD.
//     * HOLD: o_inst_valid=1 and o_fetch_ready=0.
//       - The bundle is stable until i_inst_ready.
//       - On i_inst_ready, go to OPC. This costs one bubble cycle per instruction.
//   - Latency: o_inst_valid rises in the cycle after the handshake that completes the frame.
//   - Illegal argc (argc>MAX_ARGS) at opcode handshake: o_err pulses the next cycle, the opcode
//     is dropped (no bundle), and the state stays OPC.
//   - Interrupt, sampled in OPC or ARGS:
//     * o_fetch_ready is forced 0 in the same cycle, so no word is consumed.
//     * If the stack is not full: push {state,cnt,opcode,argc,args}, clear the working frame,
//       go to OPC, and pulse o_int_ack in the next cycle.
//     * A push happens even in OPC with an empty frame, to keep push/pop paired.
//     * If the stack is full: o_err pulses, nothing is pushed, no ack is given, and the
//       interrupt is ignored while full.
//   - Interrupt in HOLD is deferred until the bundle handshake completes. It is then taken
//     in OPC on the following cycle if still asserted.
//   - i_int_return is accepted only in OPC with no interrupt active.
//     * o_fetch_ready=0 that cycle.
//     * Pop and restore the full frame and state. The next cycle continues from the restored cnt.
//     * If the stack is empty: o_err pulses and the state is unchanged.
//     * Return in ARGS or HOLD is ignored with no error. The return source must hold it until
//       the decoder is in OPC.
//   - i_interrupt and i_int_return in the same cycle: the interrupt wins; the return is dropped
//     and o_err pulses.
//   - Stack pointer range 0..SAVE_DEPTH; o_save_full and o_save_empty are registered from it.
//   - Reset mid-frame or mid-ISR discards the working frame and all saved frames immediately.
// TESTING
//   1. Reset, then fetch 0x1003 (argc=1) and 0x00AA with ready=1:
//      o_inst_valid one cycle later; opcode=0x1003, argc=1, args={0,0,0x00AA}.
//   2. Fetch 0x3005, 0x1111, 0x2222, 0x3333 with i_inst_ready=0 for 4 cycles:
//      bundle holds and o_fetch_ready=0; on ready, OPC resumes.
//   3. Fetch 0x2001, 0x0001, then i_interrupt: o_int_ack, o_save_empty=0. The ISR instruction
//      0x0000 bundles with argc=0. i_int_return, then word 0x0002: bundle 0x2001 {0x0001,0x0002}.
//   4. Three nested interrupts with SAVE_DEPTH=2: the 3rd gives o_err, no ack, o_save_full=1.
//   5. i_int_return with the stack empty: o_err pulse. Opcode 0x3000 with MAX_ARGS=2: o_err,
//      no bundle.
//   6. Assert rst in ARGS with 2 frames saved: all outputs 0, o_save_empty=1, state OPC.

Source files
------------

// File: rtl/inst_frame_decoder.sv
// Instruction-frame front end: assembles opcode plus argument words from the fetch stream into one bundle,
// and saves/restores partially assembled frames on a small interrupt shadow stack.
module inst_frame_decoder #(
  parameter  int DATA_W     = 16,
  parameter  int MAX_ARGS   = 3,
  parameter  int ARGC_LSB   = 12,
  parameter  int SAVE_DEPTH = 2,
  localparam int AW         = $clog2(MAX_ARGS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            i_fetch_data,
  input  logic                         i_fetch_valid,
  output logic                         o_fetch_ready,
  output logic                         o_inst_valid,
  input  logic                         i_inst_ready,
  output logic [DATA_W-1:0]            o_opcode,
  output logic [AW-1:0]                o_argc,
  output logic [MAX_ARGS*DATA_W-1:0]   o_args,
  input  logic                         i_interrupt,
  input  logic                         i_int_return,
  output logic                         o_int_ack,
  output logic                         o_save_full,
  output logic                         o_save_empty,
  output logic                         o_err
);

  localparam int SW = $clog2(SAVE_DEPTH + 1);
  localparam int IW = (SAVE_DEPTH > 1) ? $clog2(SAVE_DEPTH) : 1;
  localparam int SN = 1 << IW;

  typedef enum logic [1:0] {OPC, ARGS, HOLD} state_t;
  typedef logic [MAX_ARGS-1:0][DATA_W-1:0] args_t;

  state_t              state_q, state_n;
  logic [AW-1:0]       cnt_q, cnt_n, argc_q, argc_n, argc_in;
  logic [DATA_W-1:0]   opcode_q, opcode_n;
  args_t               args_q, args_n;
  logic [SW-1:0]       sp_q, sp_n;
  logic                err_q, err_n, ack_q, ack_n, full_q, empty_q;
  logic                push, active, stk_full, int_take, int_ovf, ret_req, fetch_hs;
  logic [IW-1:0]       push_idx, pop_idx;

  state_t              stk_state [SN];
  logic [AW-1:0]       stk_cnt   [SN];
  logic [AW-1:0]       stk_argc  [SN];
  logic [DATA_W-1:0]   stk_op    [SN];
  args_t               stk_args  [SN];

  assign active   = (state_q != HOLD);
  assign stk_full = (sp_q == SW'(SAVE_DEPTH));
  assign int_take = active && i_interrupt && !stk_full;
  assign int_ovf  = active && i_interrupt && stk_full;
  assign ret_req  = (state_q == OPC) && i_int_return;
  assign push_idx = sp_q[IW-1:0];
  assign pop_idx  = IW'(sp_q - 1'b1);
  assign argc_in  = i_fetch_data[ARGC_LSB +: AW];

  // A word is never consumed in a cycle that is busy with an interrupt push or a return pop.
  assign o_fetch_ready = active && !int_take && !ret_req && !rst;
  assign fetch_hs      = i_fetch_valid && o_fetch_ready;

  assign o_inst_valid = (state_q == HOLD);
  assign o_opcode     = opcode_q;
  assign o_argc       = argc_q;
  assign o_args       = args_q;
  assign o_int_ack    = ack_q;
  assign o_err        = err_q;
  assign o_save_full  = full_q;
  assign o_save_empty = empty_q;

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    opcode_n = opcode_q;
    argc_n   = argc_q;
    args_n   = args_q;
    sp_n     = sp_q;
    push     = 1'b0;
    err_n    = 1'b0;
    ack_n    = 1'b0;
    if (int_take) begin
      push     = 1'b1;
      sp_n     = sp_q + 1'b1;
      state_n  = OPC;
      cnt_n    = '0;
      opcode_n = '0;
      argc_n   = '0;
      args_n   = '0;
      ack_n    = 1'b1;
      err_n    = ret_req;
    end else if (int_ovf) begin
      err_n = 1'b1;
    end else if (ret_req) begin
      if (sp_q == '0) begin
        err_n = 1'b1;
      end else begin
        sp_n     = sp_q - 1'b1;
        state_n  = stk_state[pop_idx];
        cnt_n    = stk_cnt[pop_idx];
        opcode_n = stk_op[pop_idx];
        argc_n   = stk_argc[pop_idx];
        args_n   = stk_args[pop_idx];
      end
    end else begin
      case (state_q)
        OPC: if (fetch_hs) begin
          if (int'(argc_in) > MAX_ARGS) begin
            err_n = 1'b1;
          end else begin
            opcode_n = i_fetch_data;
            argc_n   = argc_in;
            args_n   = '0;
            cnt_n    = '0;
            state_n  = (argc_in == '0) ? HOLD : ARGS;
          end
        end
        ARGS: if (fetch_hs) begin
          for (int k = 0; k < MAX_ARGS; k++)
            if (cnt_q == AW'(k)) args_n[k] = i_fetch_data;
          cnt_n = AW'(cnt_q + 1'b1);
          if (AW'(cnt_q + 1'b1) == argc_q) state_n = HOLD;
        end
        HOLD: if (i_inst_ready) state_n = OPC;
        default: state_n = OPC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= OPC;
      cnt_q    <= '0;
      opcode_q <= '0;
      argc_q   <= '0;
      args_q   <= '0;
      sp_q     <= '0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      opcode_q <= opcode_n;
      argc_q   <= argc_n;
      args_q   <= args_n;
      sp_q     <= sp_n;
      err_q    <= err_n;
      ack_q    <= ack_n;
      full_q   <= (sp_n == SW'(SAVE_DEPTH));
      empty_q  <= (sp_n == '0);
    end
  end

  // Stack storage needs no reset: the pointer alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      stk_state[push_idx] <= state_q;
      stk_cnt[push_idx]   <= cnt_q;
      stk_op[push_idx]    <= opcode_q;
      stk_argc[push_idx]  <= argc_q;
      stk_args[push_idx]  <= args_q;
    end
  end

endmodule

// File: tb/tb_inst_frame_decoder.sv
// Scoreboard bench for inst_frame_decoder: directed frames, interrupt save/restore, error pulses and reset.
module tb_inst_frame_decoder;

  typedef struct {
    logic [15:0] op;
    logic [1:0]  argc;
    logic [47:0] args;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fetch_data;
  logic        fetch_valid, fetch_ready, inst_valid, inst_ready;
  logic [15:0] opcode;
  logic [1:0]  argc;
  logic [47:0] args;
  logic        interrupt, int_return, int_ack, save_full, save_empty, err;

  logic [15:0] fetch_data2;
  logic        fetch_valid2, fetch_ready2, inst_valid2, inst_ready2;
  logic [15:0] opcode2;
  logic [1:0]  argc2;
  logic [31:0] args2;
  logic        interrupt2, int_return2, int_ack2, save_full2, save_empty2, err2;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  inst_frame_decoder dut (
    .clk(clk), .rst(rst),
    .i_fetch_data(fetch_data), .i_fetch_valid(fetch_valid), .o_fetch_ready(fetch_ready),
    .o_inst_valid(inst_valid), .i_inst_ready(inst_ready),
    .o_opcode(opcode), .o_argc(argc), .o_args(args),
    .i_interrupt(interrupt), .i_int_return(int_return), .o_int_ack(int_ack),
    .o_save_full(save_full), .o_save_empty(save_empty), .o_err(err)
  );

  inst_frame_decoder #(.MAX_ARGS(2)) dut2 (
    .clk(clk), .rst(rst),
    .i_fetch_data(fetch_data2), .i_fetch_valid(fetch_valid2), .o_fetch_ready(fetch_ready2),
    .o_inst_valid(inst_valid2), .i_inst_ready(inst_ready2),
    .o_opcode(opcode2), .o_argc(argc2), .o_args(args2),
    .i_interrupt(interrupt2), .i_int_return(int_return2), .o_int_ack(int_ack2),
    .o_save_full(save_full2), .o_save_empty(save_empty2), .o_err(err2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] w);
    bit done;
    done = 1'b0;
    fetch_data  = w;
    fetch_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (fetch_ready) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL fetch_timeout: word %0h never accepted", w);
    end
    step();
    fetch_valid = 1'b0;
  endtask

  task automatic expect_bundle(input logic [15:0] op, input logic [1:0] ac, input logic [47:0] a);
    exp_t e;
    e.op = op; e.argc = ac; e.args = a;
    exp_q.push_back(e);
  endtask

  // Monitor: every bundle handshake is checked against the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bundle", {48'h0, opcode}, 64'hDEAD_0000_0000_0000);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("bundle_opcode", {48'h0, opcode}, {48'h0, e.op});
        chk("bundle_argc", {62'h0, argc}, {62'h0, e.argc});
        chk("bundle_args", {16'h0, args}, {16'h0, e.args});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    fetch_data = '0; fetch_valid = 1'b0; inst_ready = 1'b1;
    interrupt = 1'b0; int_return = 1'b0;
    fetch_data2 = '0; fetch_valid2 = 1'b0; inst_ready2 = 1'b1;
    interrupt2 = 1'b0; int_return2 = 1'b0;

    step(); step();
    @(negedge clk);
    chk("rst_fetch_ready", {63'h0, fetch_ready}, 64'h0);
    chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst_save_empty", {63'h0, save_empty}, 64'h1);
    chk("rst_save_full", {63'h0, save_full}, 64'h0);
    chk("rst_err_ack", {62'h0, err, int_ack}, 64'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("opc_fetch_ready", {63'h0, fetch_ready}, 64'h1);
    step();

    // Single-argument instruction, bundle one cycle after the last word.
    expect_bundle(16'h1003, 2'd1, 48'h0000_0000_00AA);
    fetch(16'h1003);
    fetch(16'h00AA);
    @(negedge clk);
    chk("t1_latency_valid", {63'h0, inst_valid}, 64'h1);
    step();

    // Full three-argument frame held under back-pressure.
    inst_ready = 1'b0;
    expect_bundle(16'h3005, 2'd3, 48'h3333_2222_1111);
    fetch(16'h3005);
    fetch(16'h1111);
    fetch(16'h2222);
    fetch(16'h3333);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", {63'h0, inst_valid}, 64'h1);
      chk("t2_hold_ready", {63'h0, fetch_ready}, 64'h0);
      chk("t2_hold_opcode", {48'h0, opcode}, 64'h3005);
    end
    step();
    inst_ready = 1'b1;
    step();
    @(negedge clk);
    chk("t2_opc_resume", {63'h0, fetch_ready}, 64'h1);
    step();

    // Interrupt mid-frame, ISR instruction, return and completion.
    fetch(16'h2001);
    fetch(16'h0001);
    interrupt = 1'b1;
    @(negedge clk);
    chk("t3_int_blocks_fetch", {63'h0, fetch_ready}, 64'h0);
    step();
    interrupt = 1'b0;
    @(negedge clk);
    chk("t3_int_ack", {63'h0, int_ack}, 64'h1);
    chk("t3_save_empty", {63'h0, save_empty}, 64'h0);
    chk("t3_cleared_opcode", {48'h0, opcode}, 64'h0);
    step();
    expect_bundle(16'h0000, 2'd0, 48'h0);
    fetch(16'h0000);
    step();
    int_return = 1'b1;
    @(negedge clk);
    chk("t3_ret_blocks_fetch", {63'h0, fetch_ready}, 64'h0);
    step();
    int_return = 1'b0;
    @(negedge clk);
    chk("t3_restored_opcode", {48'h0, opcode}, 64'h2001);
    chk("t3_restored_empty", {63'h0, save_empty}, 64'h1);
    step();
    expect_bundle(16'h2001, 2'd2, 48'h0000_0002_0001);
    fetch(16'h0002);
    step();

    // Return with nothing saved.
    int_return = 1'b1;
    @(negedge clk);
    chk("t5_ret_empty_ready", {63'h0, fetch_ready}, 64'h0);
    step();
    int_return = 1'b0;
    @(negedge clk);
    chk("t5_underflow_err", {63'h0, err}, 64'h1);
    @(negedge clk);
    chk("t5_err_is_pulse", {63'h0, err}, 64'h0);
    chk("t5_still_empty", {63'h0, save_empty}, 64'h1);

    // Illegal argument count on a MAX_ARGS=2 instance.
    step();
    fetch_data2  = 16'h3000;
    fetch_valid2 = 1'b1;
    @(negedge clk);
    chk("t5_dut2_ready", {63'h0, fetch_ready2}, 64'h1);
    step();
    fetch_valid2 = 1'b0;
    @(negedge clk);
    chk("t5_illegal_err", {63'h0, err2}, 64'h1);
    chk("t5_illegal_novalid", {63'h0, inst_valid2}, 64'h0);
    @(negedge clk);
    chk("t5_illegal_err_pulse", {63'h0, err2}, 64'h0);
    chk("t5_illegal_stay_opc", {62'h0, inst_valid2, fetch_ready2}, 64'h1);

    // Nested interrupts until the stack overflows.
    for (int n = 0; n < 3; n++) begin
      step();
      interrupt = 1'b1;
      step();
      interrupt = 1'b0;
      @(negedge clk);
      chk("t4_ack", {63'h0, int_ack}, (n < 2) ? 64'h1 : 64'h0);
      chk("t4_err", {63'h0, err}, (n < 2) ? 64'h0 : 64'h1);
      chk("t4_full", {63'h0, save_full}, (n == 0) ? 64'h0 : 64'h1);
    end
    @(negedge clk);
    chk("t4_err_pulse", {63'h0, err}, 64'h0);

    // Reset in ARGS with two frames saved.
    step();
    fetch(16'h2001);
    @(negedge clk);
    chk("t6_in_args", {62'h0, inst_valid, fetch_ready}, 64'h1);
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", {63'h0, fetch_ready}, 64'h0);
    chk("t6_rst_valid", {63'h0, inst_valid}, 64'h0);
    chk("t6_rst_empty", {63'h0, save_empty}, 64'h1);
    chk("t6_rst_full", {63'h0, save_full}, 64'h0);
    chk("t6_rst_opcode", {48'h0, opcode}, 64'h0);
    chk("t6_rst_args", {16'h0, args}, 64'h0);
    step(); step();
    rst = 1'b0;
    expect_bundle(16'h1007, 2'd1, 48'h0000_0000_0BEE);
    fetch(16'h1007);
    fetch(16'h0BEE);
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
